// File: rtl/slot_alloc64_pkg.sv
// Shared sizing, FSM encodings and the lowest-set-bit helper for the slot allocator.
package slot_alloc64_pkg;

    localparam int N = 64;
    localparam int W = 6;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        WAIT  = 2'd1,
        OFFER = 2'd2
    } state_t;

    function automatic logic [W-1:0] lowestSet(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/slot_alloc64_pe64.sv
// Purpose: 64-bit priority encoder, lowest set bit of oht wins.
// Latency: one register stage; bin/vld describe the previous cycle's oht.
// Backpressure: none, samples every cycle.
module pe64
    import slot_alloc64_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] oht,
    output logic [W-1:0] bin,
    output logic         vld
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin <= '0;
            vld <= 1'b0;
        end else begin
            bin <= lowestSet(oht);
            vld <= |oht;
        end
    end

endmodule

// File: rtl/slot_alloc64.sv
// Purpose: busy-bitmap allocator offering the lowest free slot of 64, plus a release port.
// Latency: offer appears 3 cycles after entering SCAN; busy/count/full/rel_err registered.
// Backpressure: offer held with a stable index while alloc_rdy is low; releases never stall.
module slot_alloc64
    import slot_alloc64_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic         alloc_vld,
    input  logic         alloc_rdy,
    output logic [W-1:0] alloc_idx,
    input  logic         rel_vld,
    input  logic [W-1:0] rel_idx,
    output logic         rel_err,
    output logic [W:0]   count,
    output logic         full
);

    state_t         state;
    logic [N-1:0]   busy;
    logic [N-1:0]   busyNext;
    logic [W:0]     countNext;
    logic [W-1:0]   peBin;
    logic           peVld;
    logic           grant;
    logic           relHit;

    pe64 uPe (
        .clk (clk),
        .rst (rst),
        .oht (~busy),
        .bin (peBin),
        .vld (peVld)
    );

    assign alloc_vld = (state == OFFER);
    assign grant     = (state == OFFER) && alloc_rdy;
    assign relHit    = rel_vld && busy[rel_idx];

    // The offered slot is free, so a release of it can never hit and never collides with the grant.
    always_comb begin
        busyNext = busy;
        if (relHit) busyNext[rel_idx] = 1'b0;
        if (grant)  busyNext[alloc_idx] = 1'b1;
        countNext = count + {{W{1'b0}}, grant} - {{W{1'b0}}, relHit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            busy      <= '0;
            count     <= '0;
            full      <= 1'b0;
            alloc_idx <= '0;
            rel_err   <= 1'b0;
        end else if (clr) begin
            state     <= SCAN;
            busy      <= '0;
            count     <= '0;
            full      <= 1'b0;
            rel_err   <= 1'b0;
        end else begin
            busy    <= busyNext;
            count   <= countNext;
            full    <= (countNext == (W+1)'(N));
            rel_err <= rel_vld && !busy[rel_idx];
            unique case (state)
                SCAN: state <= WAIT;
                WAIT: begin
                    if (peVld) begin
                        alloc_idx <= peBin;
                        state     <= OFFER;
                    end else begin
                        state <= SCAN;
                    end
                end
                OFFER: if (alloc_rdy) state <= SCAN;
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_alloc64.sv
// Self-checking bench for slot_alloc64: grant scoreboard, release vector table, clr/rst corner sequences.
module tb_slot_alloc64;
    import slot_alloc64_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         alloc_rdy = 1'b0;
    logic         rel_vld = 1'b0;
    logic [W-1:0] rel_idx = '0;
    logic         alloc_vld;
    logic [W-1:0] alloc_idx;
    logic         rel_err;
    logic [W:0]   count;
    logic         full;

    int checks = 0;
    int errors = 0;
    int expQ[$];

    typedef struct {
        logic [W-1:0] idx;
        logic         expErr;
        int           expCount;
    } relVec_t;

    relVec_t relTab[5];
    int      expCyc[3];

    slot_alloc64 dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .alloc_vld (alloc_vld),
        .alloc_rdy (alloc_rdy),
        .alloc_idx (alloc_idx),
        .rel_vld   (rel_vld),
        .rel_idx   (rel_idx),
        .rel_err   (rel_err),
        .count     (count),
        .full      (full)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic waitOffer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (alloc_vld) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok && alloc_vld) ok = 1'b1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout got no alloc_vld expected an offer within 8 cycles");
        end
    endtask

    // Expected index is queued before the consumer is made ready; popped at the handshake.
    task automatic doGrant(input int expIdx);
        bit ok;
        expQ.push_back(expIdx);
        alloc_rdy = 1'b1;
        waitOffer(ok);
        if (ok) begin
            int e;
            e = expQ.pop_front();
            chk("grant_idx", 64'(alloc_idx), 64'(e));
        end else begin
            void'(expQ.pop_front());
        end
        @(negedge clk);
        alloc_rdy = 1'b0;
    endtask

    initial begin
        bit ok;
        bit seen;
        int g;

        expCyc[0] = 2; expCyc[1] = 5; expCyc[2] = 8;
        relTab[0] = '{idx: 6'd40, expErr: 1'b1, expCount: 6};
        relTab[1] = '{idx: 6'd2,  expErr: 1'b1, expCount: 6};
        relTab[2] = '{idx: 6'd6,  expErr: 1'b0, expCount: 5};
        relTab[3] = '{idx: 6'd6,  expErr: 1'b1, expCount: 5};
        relTab[4] = '{idx: 6'd0,  expErr: 1'b0, expCount: 4};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_alloc_vld", 64'(alloc_vld), 64'd0);
        chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("rst_rel_err",   64'(rel_err),   64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_full",      64'(full),      64'd0);

        // back-to-back grants with ready held high
        rst = 1'b0;
        alloc_rdy = 1'b1;
        expQ.push_back(0); expQ.push_back(1); expQ.push_back(2);
        g = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (alloc_vld && g < 3) begin
                chk("grant_cycle", 64'(cyc), 64'(expCyc[g]));
                chk("grant_idx", 64'(alloc_idx), 64'(expQ.pop_front()));
                g++;
            end
        end
        alloc_rdy = 1'b0;
        chk("grants_seen", 64'(g), 64'd3);
        expQ.delete();
        chk("count_after_3", 64'(count), 64'd3);

        // fill the table
        for (int i = 3; i < 64; i++) doGrant(i);
        chk("full_count", 64'(count), 64'd64);
        chk("full_flag",  64'(full),  64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (alloc_vld) seen = 1'b1;
        end
        chk("full_no_offer", 64'(seen), 64'd0);

        // freeing one slot while full
        rel_vld = 1'b1; rel_idx = 6'd17;
        @(negedge clk);
        rel_vld = 1'b0;
        chk("rel17_count",   64'(count),   64'd63);
        chk("rel17_rel_err", 64'(rel_err), 64'd0);
        chk("rel17_full",    64'(full),    64'd0);
        seen = alloc_vld;
        repeat (3) begin
            @(negedge clk);
            if (alloc_vld) seen = 1'b1;
        end
        chk("rel17_offer_in_time", 64'(seen), 64'd1);
        chk("rel17_offer_idx", 64'(alloc_idx), 64'd17);
        doGrant(17);
        chk("refull_flag",  64'(full),  64'd1);
        chk("refull_count", 64'(count), 64'd64);

        // plain flush
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_count",     64'(count),     64'd0);
        chk("clr_full",      64'(full),      64'd0);
        chk("clr_alloc_vld", 64'(alloc_vld), 64'd0);

        // offer held under backpressure
        for (int i = 0; i < 5; i++) doGrant(i);
        waitOffer(ok);
        chk("hold_first_idx", 64'(alloc_idx), 64'd5);
        repeat (10) begin
            @(negedge clk);
            chk("hold_idx",   64'(alloc_idx), 64'd5);
            chk("hold_vld",   64'(alloc_vld), 64'd1);
            chk("hold_count", 64'(count),     64'd5);
        end
        doGrant(5);
        chk("one_grant_count", 64'(count), 64'd6);
        repeat (6) @(negedge clk);
        chk("one_grant_stable", 64'(count), 64'd6);

        // a lower slot freed during OFFER is not reconsidered
        waitOffer(ok);
        chk("offer6_idx", 64'(alloc_idx), 64'd6);
        rel_vld = 1'b1; rel_idx = 6'd4;
        @(negedge clk);
        rel_vld = 1'b0;
        chk("rel4_count", 64'(count), 64'd5);
        doGrant(6);
        chk("grant6_count", 64'(count), 64'd6);

        // grant 4 and release 2 in the same cycle
        waitOffer(ok);
        chk("offer4_idx", 64'(alloc_idx), 64'd4);
        alloc_rdy = 1'b1; rel_vld = 1'b1; rel_idx = 6'd2;
        @(negedge clk);
        alloc_rdy = 1'b0; rel_vld = 1'b0;
        chk("simul_count",   64'(count),        64'd6);
        chk("simul_rel_err", 64'(rel_err),      64'd0);
        chk("simul_busy4",   64'(dut.busy[4]),  64'd1);
        chk("simul_busy2",   64'(dut.busy[2]),  64'd0);
        waitOffer(ok);
        chk("offer2_idx", 64'(alloc_idx), 64'd2);

        // release vectors while idx 2 is on offer
        for (int v = 0; v < 5; v++) begin
            rel_vld = 1'b1; rel_idx = relTab[v].idx;
            @(negedge clk);
            rel_vld = 1'b0;
            chk("relvec_err",   64'(rel_err),   64'(relTab[v].expErr));
            chk("relvec_count", 64'(count),     64'(relTab[v].expCount));
            chk("relvec_vld",   64'(alloc_vld), 64'd1);
            chk("relvec_idx",   64'(alloc_idx), 64'd2);
            @(negedge clk);
            chk("relvec_err_pulse", 64'(rel_err), 64'd0);
        end

        // flush in OFFER racing a handshake and a bad release
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) doGrant(i);
        chk("ten_count", 64'(count), 64'd10);
        waitOffer(ok);
        chk("offer10_idx", 64'(alloc_idx), 64'd10);
        alloc_rdy = 1'b1; clr = 1'b1; rel_vld = 1'b1; rel_idx = 6'd40;
        @(negedge clk);
        alloc_rdy = 1'b0; clr = 1'b0; rel_vld = 1'b0;
        chk("clrh_count",     64'(count),     64'd0);
        chk("clrh_alloc_vld", 64'(alloc_vld), 64'd0);
        chk("clrh_busy",      dut.busy,       64'd0);
        chk("clrh_full",      64'(full),      64'd0);
        chk("clrh_rel_err",   64'(rel_err),   64'd0);
        waitOffer(ok);
        chk("clrh_next_idx", 64'(alloc_idx), 64'd0);

        // asynchronous reset in WAIT
        doGrant(0);
        doGrant(1);
        @(negedge clk);
        chk("pre_rst_state", 64'(dut.state), 64'(WAIT));
        chk("pre_rst_count", 64'(count),     64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_alloc_vld", 64'(alloc_vld), 64'd0);
        chk("arst_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("arst_rel_err",   64'(rel_err),   64'd0);
        chk("arst_count",     64'(count),     64'd0);
        chk("arst_full",      64'(full),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_alloc64.md
# slot_alloc64

Free-slot allocator for a 64-entry tracking table. It keeps a busy bitmap and drives the pipelined 64-bit priority encoder (pe64) to locate the lowest free slot. It offers that slot to a single consumer over a valid/ready handshake, and accepts slot releases from a second port. It sits between the table's insert logic (consumer) and its retire logic (releaser).

## Interface
- N, 64: number of slots; fixed by pe64 width.
- W, 6: index width, log2(N).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush: frees all slots and aborts any offer.
- alloc_vld  out  1  a free slot index is offered on alloc_idx.
- alloc_rdy  in  1  consumer accepts the offered slot.
- alloc_idx  out  W  offered slot index; stable while alloc_vld=1.
- rel_vld  in  1  release request.
- rel_idx  in  W  slot to release.
- rel_err  out  1  one-cycle pulse: the released slot was not busy.
- count  out  W+1  number of busy slots, 0..64.
- full  out  1  count==64.

## Operation
- Reset (rst=1) sets busy=0, count=0, state=SCAN, alloc_vld=0, alloc_idx=0, rel_err=0 and full=0.
- pe64 input is ~busy, and it has one internal register stage. Its bin/vld outputs reflect the mask from the previous cycle. The lowest set index wins.
- FSM:
  - SCAN: the encoder samples the current free mask. Next state is WAIT.
  - WAIT: if encoder vld=1, latch bin into alloc_idx and go to OFFER. If vld=0 (no free slot), go to SCAN and retry.
  - OFFER: alloc_vld=1. If alloc_rdy=1, set busy[alloc_idx], increment count and go to SCAN. Otherwise stay in OFFER with alloc_idx held.
- Release: if rel_vld=1 and busy[rel_idx]=1, clear the bit and decrement count at the edge. If the bit is not busy, change no state and pulse rel_err=1 in the next cycle.
- Simultaneous grant and valid release of a different slot: both take effect and count is unchanged.
- Releasing the slot currently offered is always an error, because that slot is free. It produces rel_err and the offer is unaffected.
- Allocation fairness: the slot granted is the lowest free slot as of the SCAN cycle. A lower slot freed during WAIT or OFFER is not reconsidered until the next SCAN.
- clr has priority over grant and release. At the edge it sets busy=0, count=0, state=SCAN and alloc_vld=0. A handshake completing in that same cycle is discarded. It also suppresses rel_err.
- Only this block sets busy bits, so an offered index is guaranteed free until it is granted.
- count is never driven out of range. An increment at 64 cannot occur, because OFFER is unreachable when full.

## Timing
- Search latency: alloc_vld rises on the 3rd cycle after entering SCAN (SCAN, WAIT, OFFER).
- With alloc_rdy held high, the peak rate is one grant per 3 cycles.
- busy, count and full update on the grant edge and are visible the next cycle.
- rel_err is registered: it is high in the cycle after the offending rel_vld.
- All outputs are registered except alloc_vld, which is decoded from the state register.
- Full state: the FSM cycles SCAN→WAIT→SCAN with alloc_vld=0. The first offer comes 3 cycles after the first SCAN that sees a freed slot.

## Structure
- Shared package or header holds N=64, W=6 and the state encodings (SCAN=2'd0, WAIT=2'd1, OFFER=2'd2).
- One sub-module instance: pe64 (clk, rst, oht=~busy, bin, vld). No other hierarchy.

## Test plan
- After reset, hold alloc_rdy=1 → grants of idx 0, 1, 2 on cycles 2, 5, 8; count=3.
- Allocate all 64 slots → full=1 and count=64, with alloc_vld staying 0. Release slot 17 → alloc_vld with idx 17 within 3 cycles after the release edge. Grant it → full=1 again.
- Keep alloc_rdy=0 in OFFER with idx 5 for 10 cycles → alloc_idx stays 5 and count does not change. Raise alloc_rdy → one grant only.
- Grant slot 4 and release busy slot 2 in the same cycle → count unchanged, busy[4]=1, busy[2]=0. The next offer is idx 2.
- Release free slot 40 → rel_err pulses exactly one cycle and count is unchanged. Release the currently offered idx → rel_err=1 and the offer persists.
- Assert clr in OFFER together with alloc_rdy=1 after 10 grants → count=0 and busy all zero. No grant is recorded, and the next offer is idx 0. Assert rst mid-WAIT → all outputs return to reset values asynchronously.
